// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline control unit.
// Next-PC select codes, FSM states, default vectors and mult/div latency.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        PC_SEL_SEQ = 3'd0,
        PC_SEL_BR  = 3'd1,
        PC_SEL_J   = 3'd2,
        PC_SEL_VEC = 3'd3,
        PC_SEL_EPC = 3'd4
    } pc_sel_t;

    typedef enum logic {
        RUN        = 1'b0,
        TRAP_ENTER = 1'b1
    } state_t;

    localparam logic [31:0] DEF_IRQ_VEC = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC = 32'h8000_0008;
    localparam int unsigned DEF_MD_LAT  = 8;
    localparam int unsigned MD_CNT_W    = 4;

    // A trap cause of 1 means illegal instruction, 0 means interrupt.
    function automatic logic [31:0] trap_target(input logic cause_exc,
                                                input logic [31:0] irq_vec,
                                                input logic [31:0] exc_vec);
        return cause_exc ? exc_vec : irq_vec;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-control signal bundle.
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_jump;
    logic        id_eret;
    logic        id_exc;
    logic        id_md_start;
    logic        id_md_read;
    logic        ex_mem_read;
    logic [4:0]  ex_rt_dst;
    logic        ex_branch_taken;
    logic        irq;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    pc_sel_t     pc_sel;
    logic [31:0] trap_vec;
    logic [31:0] epc;
    logic        kernel;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_jump, id_eret, id_exc, id_md_start, id_md_read,
               ex_mem_read, ex_rt_dst, ex_branch_taken, irq,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel,
               trap_vec, epc, kernel, md_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_jump, id_eret, id_exc, id_md_start, id_md_read,
               ex_mem_read, ex_rt_dst, ex_branch_taken, irq,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel,
               trap_vec, epc, kernel, md_busy, stall_cnt
    );

endinterface

// File: rtl/md_busy_timer.sv
// Mult/div latency timer: loads the latency on issue, counts down to zero.
// A load wins over the decrement; busy while the count is nonzero.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = DEF_MD_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LAT);

    logic [MD_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAT;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/trap control: stage enables, flushes and next-PC select,
// plus the EPC register, kernel-mode bit and stall-cycle counter.
//
// state      | meaning
// RUN        | normal issue; branch, trap capture, stalls, ERET, jump
// TRAP_ENTER | one cycle redirecting fetch to the trap vector
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = DEF_IRQ_VEC,
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC,
    parameter int unsigned MD_LAT  = DEF_MD_LAT
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    state_t      state;
    state_t      state_nxt;
    logic        cause_exc;
    logic [31:0] epc_q;
    logic        kernel_q;
    logic [31:0] stall_cnt_q;
    logic        md_busy;

    logic        load_use;
    logic        md_hazard;
    logic        trap_take;

    logic        pc_write_c;
    logic        if_id_write_c;
    logic        if_id_flush_c;
    logic        id_ex_flush_c;
    pc_sel_t     pc_sel_c;
    logic        trap_capture;
    logic        eret_do;
    logic        md_load;

    assign load_use = bus.ex_mem_read && (bus.ex_rt_dst != 5'd0) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt_dst)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rt_dst)));

    assign md_hazard = bus.id_valid && (bus.id_md_read || bus.id_md_start) && md_busy;

    // Bubbles never trap, so an irq waits for a real instruction to own the EPC.
    assign trap_take = bus.id_valid && (bus.id_exc || (bus.irq && !kernel_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        pc_sel_c      = PC_SEL_SEQ;
        trap_capture  = 1'b0;
        eret_do       = 1'b0;
        md_load       = 1'b0;

        case (state)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    pc_sel_c      = PC_SEL_BR;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (trap_take) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                    trap_capture  = 1'b1;
                    state_nxt     = TRAP_ENTER;
                end else if (load_use || md_hazard) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                end else begin
                    md_load = bus.id_valid && bus.id_md_start;
                    if (bus.id_valid && bus.id_eret) begin
                        pc_sel_c      = PC_SEL_EPC;
                        if_id_flush_c = 1'b1;
                        eret_do       = 1'b1;
                    end else if (bus.id_valid && bus.id_jump) begin
                        pc_sel_c      = PC_SEL_J;
                        if_id_flush_c = 1'b1;
                    end
                end
            end
            TRAP_ENTER: begin
                pc_sel_c      = PC_SEL_VEC;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                state_nxt     = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            epc_q       <= '0;
            cause_exc   <= 1'b0;
            kernel_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (trap_capture) begin
                epc_q     <= bus.id_pc;
                cause_exc <= bus.id_exc;
            end
            if (state == TRAP_ENTER) begin
                kernel_q <= 1'b1;
            end else if (eret_do) begin
                kernel_q <= 1'b0;
            end
            if (!pc_write_c) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    md_busy_timer #(.MD_LAT(MD_LAT)) u_md_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (md_load),
        .md_busy (md_busy)
    );

    assign bus.pc_write    = pc_write_c;
    assign bus.if_id_write = if_id_write_c;
    assign bus.if_id_flush = if_id_flush_c;
    assign bus.id_ex_flush = id_ex_flush_c;
    assign bus.pc_sel      = pc_sel_c;
    assign bus.trap_vec    = (pc_sel_c == PC_SEL_VEC) ?
                             trap_target(cause_exc, IRQ_VEC, EXC_VEC) : IRQ_VEC;
    assign bus.epc         = epc_q;
    assign bus.kernel      = kernel_q;
    assign bus.md_busy     = md_busy;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected control words queued per cycle,
// popped and compared at the falling edge; registered outputs checked inline.
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] IRQ_V = 32'h8000_0004;
    localparam logic [31:0] EXC_V = 32'h8000_0008;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel}
    localparam logic [6:0] C_DEF   = 7'b1100_000;
    localparam logic [6:0] C_STALL = 7'b0001_000;
    localparam logic [6:0] C_BR    = 7'b1111_001;
    localparam logic [6:0] C_JMP   = 7'b1110_010;
    localparam logic [6:0] C_VEC   = 7'b1111_011;
    localparam logic [6:0] C_ERET  = 7'b1110_100;

    typedef struct {
        string       tag;
        logic [38:0] v;
    } exp_t;

    logic clk;
    logic reset;
    hazard_ctrl_if bus ();

    hazard_ctrl #(.IRQ_VEC(IRQ_V), .EXC_VEC(EXC_V), .MD_LAT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        q[$];
    exp_t        e;
    int          n_err;
    int          n_chk;
    logic [31:0] exp_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic logic [38:0] obs();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                3'(bus.pc_sel), bus.trap_vec};
    endfunction

    task automatic drive_idle();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_jump = 0; bus.id_eret = 0;
        bus.id_exc = 0; bus.id_md_start = 0; bus.id_md_read = 0;
        bus.ex_mem_read = 0; bus.ex_rt_dst = '0; bus.ex_branch_taken = 0; bus.irq = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        drive_idle();
        next_cycle();
        next_cycle();
        q.push_back('{"reset_ctl", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if ({bus.epc, bus.kernel, bus.md_busy, bus.stall_cnt} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_regs: epc=%h kernel=%b md_busy=%b stall=%0d required all zero",
                     bus.epc, bus.kernel, bus.md_busy, bus.stall_cnt);
        end
        exp_stall = 0;
        reset = 1;
        next_cycle();
    endtask

    task automatic test_load_use();
        bus.id_valid = 1; bus.ex_mem_read = 1; bus.ex_rt_dst = 5'd5;
        bus.id_rs = 5'd5; bus.id_uses_rs = 1;
        q.push_back('{"lu_stall", {C_STALL, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        exp_stall++;
        next_cycle();
        bus.ex_mem_read = 0;
        q.push_back('{"lu_bubble", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.stall_cnt !== exp_stall) begin
            n_err++; $display("FAIL lu_stall_cnt: got %0d required %0d", bus.stall_cnt, exp_stall);
        end
        next_cycle();
        bus.ex_mem_read = 1; bus.ex_rt_dst = 5'd0; bus.id_rs = 5'd0;
        q.push_back('{"lu_r0", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.ex_rt_dst = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        q.push_back('{"lu_rt_unused", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_uses_rt = 1;
        q.push_back('{"lu_rt_used", {C_STALL, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        exp_stall++;
        next_cycle();
        drive_idle();
    endtask

    task automatic test_branch_vs_exc();
        bus.ex_branch_taken = 1; bus.id_valid = 1; bus.id_exc = 1; bus.id_pc = 32'h0000_1234;
        bus.id_md_start = 1;
        q.push_back('{"br_over_exc", {C_BR, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        drive_idle();
        q.push_back('{"br_stays_run", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.epc !== 32'd0 || bus.md_busy !== 1'b0) begin
            n_err++; $display("FAIL br_no_side_effect: epc=%h md_busy=%b required 0/0", bus.epc, bus.md_busy);
        end
        next_cycle();
    endtask

    task automatic test_irq_entry();
        bus.irq = 1;
        q.push_back('{"irq_bubble_wait", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_valid = 1; bus.id_pc = 32'h0040_0010;
        q.push_back('{"irq_capture", {C_STALL, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        exp_stall++;
        next_cycle();
        bus.id_pc = 32'h0040_0014;
        q.push_back('{"irq_vector", {C_VEC, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.epc !== 32'h0040_0010 || bus.kernel !== 1'b0) begin
            n_err++; $display("FAIL irq_epc: epc=%h kernel=%b required 00400010/0", bus.epc, bus.kernel);
        end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            q.push_back('{"irq_masked", {C_DEF, IRQ_V}});
            @(negedge clk);
            e = q.pop_front(); n_chk++;
            if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
            n_chk++;
            if (bus.kernel !== 1'b1) begin
                n_err++; $display("FAIL irq_kernel: got %b required 1", bus.kernel);
            end
            next_cycle();
        end
        n_chk++;
        if (bus.stall_cnt !== exp_stall) begin
            n_err++; $display("FAIL irq_stall_cnt: got %0d required %0d", bus.stall_cnt, exp_stall);
        end
        drive_idle();
    endtask

    task automatic test_eret_jump();
        bus.id_valid = 1; bus.id_eret = 1;
        q.push_back('{"eret", {C_ERET, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_eret = 0; bus.id_jump = 1;
        q.push_back('{"jump", {C_JMP, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.kernel !== 1'b0) begin
            n_err++; $display("FAIL eret_kernel: got %b required 0", bus.kernel);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_exception();
        bus.id_valid = 1; bus.id_exc = 1; bus.irq = 1; bus.id_pc = 32'h0000_0100;
        q.push_back('{"exc_capture", {C_STALL, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        exp_stall++;
        next_cycle();
        bus.irq = 0; bus.id_exc = 0;
        q.push_back('{"exc_vector", {C_VEC, EXC_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_exc = 1; bus.id_pc = 32'h0000_0200;
        q.push_back('{"exc_in_kernel", {C_STALL, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        exp_stall++;
        next_cycle();
        bus.id_exc = 0;
        q.push_back('{"exc_vector2", {C_VEC, EXC_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_eret = 1;
        q.push_back('{"exc_eret", {C_ERET, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.epc !== 32'h0000_0200 || bus.kernel !== 1'b1) begin
            n_err++; $display("FAIL exc_epc: epc=%h kernel=%b required 00000200/1", bus.epc, bus.kernel);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_md();
        bus.id_valid = 1; bus.id_md_start = 1;
        q.push_back('{"md_issue", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_md_start = 0; bus.id_md_read = 1;
        for (int k = 1; k <= 8; k++) begin
            q.push_back('{"md_read_stall", {C_STALL, IRQ_V}});
            @(negedge clk);
            e = q.pop_front(); n_chk++;
            if (obs() !== e.v) begin n_err++; $display("FAIL %s cycle %0d: got %h required %h", e.tag, k, obs(), e.v); end
            n_chk++;
            if (bus.md_busy !== 1'b1) begin
                n_err++; $display("FAIL md_busy cycle %0d: got %b required 1", k, bus.md_busy);
            end
            exp_stall++;
            next_cycle();
        end
        q.push_back('{"md_read_go", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.md_busy !== 1'b0 || bus.stall_cnt !== exp_stall) begin
            n_err++; $display("FAIL md_done: md_busy=%b stall=%0d required 0/%0d", bus.md_busy, bus.stall_cnt, exp_stall);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_mid_trap();
        bus.id_valid = 1; bus.id_md_start = 1;
        q.push_back('{"rmt_md_issue", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        bus.id_md_start = 0; bus.irq = 1; bus.id_pc = 32'h0000_0044;
        q.push_back('{"rmt_capture", {C_STALL, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        next_cycle();
        reset = 0;
        q.push_back('{"rmt_vector", {C_VEC, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if (bus.md_busy !== 1'b1 || bus.epc !== 32'h0000_0044) begin
            n_err++; $display("FAIL rmt_pre: md_busy=%b epc=%h required 1/00000044", bus.md_busy, bus.epc);
        end
        next_cycle();
        reset = 1;
        drive_idle();
        exp_stall = 0;
        q.push_back('{"rmt_run", {C_DEF, IRQ_V}});
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h required %h", e.tag, obs(), e.v); end
        n_chk++;
        if ({bus.epc, bus.kernel, bus.md_busy, bus.stall_cnt} !== 66'd0) begin
            n_err++;
            $display("FAIL rmt_regs: epc=%h kernel=%b md_busy=%b stall=%0d required all zero",
                     bus.epc, bus.kernel, bus.md_busy, bus.stall_cnt);
        end
        next_cycle();
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        exp_stall = 0;
        reset = 0;
        drive_idle();
        test_reset();
        test_load_use();
        test_branch_vs_exc();
        test_irq_entry();
        test_eret_jump();
        test_exception();
        test_md();
        test_reset_mid_trap();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the five-stage CPU. Every cycle it decides the PC write-enable, the IF/ID write-enable and flush, the ID/EX flush, and the next-PC select. It covers branch redirects, jumps, load-use and multiply/divide hazards, precise trap entry through a two-state FSM, and ERET. It owns the EPC register, the kernel-mode bit and a stall-cycle counter. It sits beside the IF/ID and ID/EX pipeline registers and drives their enables and flushes.

## Interface
- IRQ_VEC, 32'h8000_0004, interrupt vector.
- EXC_VEC, 32'h8000_0008, exception (illegal instruction) vector.
- MD_LAT, 8, multiply/divide latency in cycles; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low.
- id_valid  in  1  ID holds a real instruction, not a bubble.
- id_pc  in  32  PC of the ID instruction.
- id_rs, id_rt  in  5 each  ID source registers.
- id_uses_rs, id_uses_rt  in  1 each  source is actually read.
- id_jump, id_eret, id_exc  in  1 each  ID instruction is a jump / ERET / illegal instruction.
- id_md_start, id_md_read  in  1 each  ID issues mult/div / reads HI or LO.
- ex_mem_read, ex_rt_dst  in  1, 5  EX holds a load, and its destination register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- irq  in  1  level interrupt request.
- pc_write, if_id_write  out  1 each  stage enables.
- if_id_flush, id_ex_flush  out  1 each  insert a bubble.
- pc_sel  out  3  0 PC+4, 1 branch target, 2 jump target, 3 vector, 4 EPC.
- trap_vec  out  32  vector address, valid when pc_sel==3.
- epc  out  32  saved exception PC.
- kernel  out  1  kernel mode; masks irq.
- md_busy  out  1  mult/div unit still running.
- stall_cnt  out  32  number of cycles with pc_write==0.

## Operation
- FSM states are RUN and TRAP_ENTER. Reset state is RUN.
- Registers clear on reset: epc=0, kernel=0, md counter=0, stall_cnt=0, trap cause=0.
- Default outputs: pc_write=1, if_id_write=1, both flushes 0, pc_sel=0.
- In RUN, the conditions below are evaluated in priority order; the first match applies.
  1. ex_branch_taken: pc_sel=1, if_id_flush=1, id_ex_flush=1. This cancels any ID exception, ERET, jump or mult/div start. A pending irq is re-evaluated on later cycles.
  2. Trap capture, when id_valid & (id_exc | (irq & ~kernel)): pc_write=0, if_id_write=0, id_ex_flush=1.
     - epc <= id_pc.
     - cause <= exc when id_exc is set; id_exc wins over irq.
     - Next state is TRAP_ENTER.
  3. Hazard stall: pc_write=0, if_id_write=0, id_ex_flush=1. Triggers:
     - Load-use: ex_mem_read, ex_rt_dst!=0, and a used source register equals ex_rt_dst.
     - Mult/div: id_valid & (id_md_read | id_md_start) & md_busy.
  4. ERET, when id_valid & id_eret: pc_sel=4, if_id_flush=1, kernel <= 0.
  5. Jump, when id_valid & id_jump: pc_sel=2, if_id_flush=1.
- TRAP_ENTER (lasts exactly 1 cycle):
  - pc_write=1, pc_sel=3, trap_vec = cause ? EXC_VEC : IRQ_VEC.
  - if_id_flush=1, id_ex_flush=1.
  - kernel <= 1. Next state is RUN.
- Mult/div counter (4 bits):
  - Loads MD_LAT when id_valid & id_md_start & no priority 1–3 condition in RUN.
  - Otherwise decrements while nonzero; a load has priority over the decrement.
  - md_busy = counter!=0.
  - The counter keeps running through traps and flushes.
- stall_cnt increments every cycle pc_write==0 and wraps from 2^32−1 to 0.
- trap_vec reads IRQ_VEC when pc_sel!=3.

## Timing
- All outputs except the registered ones (epc, kernel, md_busy, stall_cnt) are combinational from inputs and state, valid in the same cycle.
- Load-use stall lasts 1 cycle: the inserted bubble removes the match on the next cycle.
- Trap latency: capture cycle, then TRAP_ENTER, then the vector is fetched in the third cycle.
  - EPC is visible the cycle after capture.
  - kernel is set the cycle after TRAP_ENTER.
- irq arriving while id_valid=0 waits until a valid instruction reaches ID; no EPC is ever taken from a bubble.
- irq while kernel=1 is ignored. id_exc is taken in kernel mode.
- Mult/div issued at edge t: md_busy is high for cycles t+1 through t+MD_LAT. An id_md_read in cycle t+MD_LAT+1 proceeds.
- Reset asserted mid-trap or mid-mult/div returns to RUN with all registers at reset values on the next edge.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - PC_SEL_SEQ/BR/J/VEC/EPC constants and a pc_sel_t typedef.
  - A state enum {RUN, TRAP_ENTER}.
  - The default vector constants.
- One sub-module, md_busy_timer: 4-bit load/decrement counter producing md_busy.
- Everything else stays in hazard_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rt_dst=5, id_rs=5, id_uses_rs=1 → one cycle of pc_write=0, id_ex_flush=1, stall_cnt=1. With ex_rt_dst=0 → no stall.
- Branch vs exception: ex_branch_taken=1 with id_exc=1 and id_valid=1 in the same cycle → pc_sel=1, both flushes set, state stays RUN, epc unchanged.
- Interrupt entry: irq=1, kernel=0, id_valid=1, id_pc=0x0040_0010 →
  - Capture cycle stalls.
  - Next cycle pc_sel=3, trap_vec=0x8000_0004, epc=0x0040_0010.
  - Then kernel=1; irq held high takes no further trap.
- ERET: from kernel=1, id_eret=1 → pc_sel=4, if_id_flush=1, kernel=0 on the next cycle.
- Mult/div: MD_LAT=8, id_md_start accepted at edge t → id_md_read stalls in cycles t+1..t+8 and proceeds in cycle t+9.
- Reset mid-trap: reset=0 during TRAP_ENTER → next edge state=RUN, epc=0, kernel=0, stall_cnt=0, md_busy=0.
